spi_frame_ctrl: RTL

// System-clock controller that sequences the 64-bit SPI slave datapath. It detects completed

---
 rtl/spi_frame_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/spi_frame_ctrl.sv
// Clock-domain sequencer for a 64-bit SPI slave: picks up each frame at chip-select release,
// runs at most one register-bus cycle for it, and stages the reply shifted out on the next frame.
module spi_frame_ctrl #(
    parameter int DATA_LENGTH    = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_LENGTH-1:0] spi_data_in,
    input  logic                   spi_data_ready,
    input  logic                   spi_cs,
    output logic [DATA_LENGTH-1:0] spi_data_out,
    output logic                   bus_req,
    output logic                   bus_we,
    output logic [7:0]             bus_addr,
    output logic [31:0]            bus_wdata,
    input  logic                   bus_ack,
    input  logic [31:0]            bus_rdata,
    output logic                   busy,
    output logic [7:0]             overrun_count
);

    localparam logic [7:0] CMD_NOP   = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_BADCMD  = 8'h01;
    localparam logic [7:0] ST_TIMEOUT = 8'h02;
    localparam logic [7:0] ST_SHORT   = 8'h03;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_DECODE,
        S_BUS,
        S_WAIT,
        S_RESP
    } state_e;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } bus_cmd_t;

    // Synchronizers: CS idles high, data_ready idles low.
    logic cs_s1_q, cs_s2_q, cs_prev_q;
    logic dr_s1_q, dr_s2_q;
    logic cs_rise;

    state_e                 state_q, state_d;
    logic                   ready_q, ready_d;
    logic [DATA_LENGTH-1:0] frame_q, frame_d;
    logic [DATA_LENGTH-1:0] resp_q, resp_d;
    logic [DATA_LENGTH-1:0] data_out_q, data_out_d;
    bus_cmd_t               bus_q, bus_d;
    logic [15:0]            wait_cnt_q, wait_cnt_d;
    logic [7:0]             ovr_q, ovr_d;

    assign cs_rise = cs_s2_q & ~cs_prev_q;

    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        frame_d    = frame_q;
        resp_d     = resp_q;
        data_out_d = data_out_q;
        bus_d      = bus_q;
        wait_cnt_d = wait_cnt_q;
        ovr_d      = ovr_q;

        // Any frame that completes while a previous one is still in flight is lost.
        if (cs_rise && (state_q != S_IDLE) && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (cs_rise) begin
                    ready_d = dr_s2_q;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                frame_d = spi_data_in;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                resp_d  = {ST_OK, frame_q[55:48], frame_q[47:32], 32'h0};
                state_d = S_RESP;
                if (!ready_q) begin
                    resp_d[63:56] = ST_SHORT;
                end else if (frame_q[63:56] == CMD_WRITE || frame_q[63:56] == CMD_READ) begin
                    state_d = S_BUS;
                end else if (frame_q[63:56] != CMD_NOP) begin
                    resp_d[63:56] = ST_BADCMD;
                end
            end
            S_BUS: begin
                bus_d.req   = 1'b1;
                bus_d.we    = (frame_q[63:56] == CMD_WRITE);
                bus_d.addr  = frame_q[55:48];
                bus_d.wdata = frame_q[31:0];
                wait_cnt_d  = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (bus_ack) begin
                    bus_d.req = 1'b0;
                    resp_d    = {ST_OK, frame_q[55:48], frame_q[47:32],
                                 bus_q.we ? frame_q[31:0] : bus_rdata};
                    state_d   = S_RESP;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    bus_d.req = 1'b0;
                    resp_d    = {ST_TIMEOUT, frame_q[55:48], frame_q[47:32], 32'h0};
                    state_d   = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                // The shifter samples spi_data_out at CS fall, so never touch it mid-frame.
                if (cs_s2_q) begin
                    data_out_d = resp_q;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_s1_q    <= 1'b1;
            cs_s2_q    <= 1'b1;
            cs_prev_q  <= 1'b1;
            dr_s1_q    <= 1'b0;
            dr_s2_q    <= 1'b0;
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            frame_q    <= '0;
            resp_q     <= '0;
            data_out_q <= '0;
            bus_q      <= '0;
            wait_cnt_q <= '0;
            ovr_q      <= '0;
        end else begin
            cs_s1_q    <= spi_cs;
            cs_s2_q    <= cs_s1_q;
            cs_prev_q  <= cs_s2_q;
            dr_s1_q    <= spi_data_ready;
            dr_s2_q    <= dr_s1_q;
            state_q    <= state_d;
            ready_q    <= ready_d;
            frame_q    <= frame_d;
            resp_q     <= resp_d;
            data_out_q <= data_out_d;
            bus_q      <= bus_d;
            wait_cnt_q <= wait_cnt_d;
            ovr_q      <= ovr_d;
        end
    end

    assign spi_data_out  = data_out_q;
    assign bus_req       = bus_q.req;
    assign bus_we        = bus_q.we;
    assign bus_addr      = bus_q.addr;
    assign bus_wdata     = bus_q.wdata;
    assign busy          = (state_q != S_IDLE);
    assign overrun_count = ovr_q;

endmodule
